// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data memory) arbiter onto one variable-latency memory port.
// Define MEM_ARBITER_PERF_EN to add stall-cycle and grant counters.
module mem_arbiter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_ack_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        stall_o,
    output logic        err_o
`ifdef MEM_ARBITER_PERF_EN
    ,
    output logic [31:0] stall_cycles_o,
    output logic [15:0] if_grants_o,
    output logic [15:0] dm_grants_o
`endif
);

    typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC, DONE} state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] wait_cnt;
    logic       grant_if;
    logic       grant_dm;
    logic       acc_done;
    logic       acc_timeout;
    logic       in_acc;

    assign in_acc  = (state == IF_ACC) || (state == DM_ACC);
    assign stall_o = (if_req_i && !if_ack_o) || (dm_req_i && !dm_ack_o);

    // Data port wins ties because it belongs to the older instruction.
    always_comb begin
        next_state  = state;
        grant_if    = 1'b0;
        grant_dm    = 1'b0;
        acc_done    = 1'b0;
        acc_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (dm_req_i) begin
                    next_state = DM_ACC;
                    grant_dm   = 1'b1;
                end else if (if_req_i) begin
                    next_state = IF_ACC;
                    grant_if   = 1'b1;
                end
            end
            IF_ACC, DM_ACC: begin
                if (mem_ack_i) begin
                    next_state = DONE;
                    acc_done   = 1'b1;
                end else if (wait_cnt == 8'd254) begin
                    // This cycle is the 255th without an ack.
                    next_state  = DONE;
                    acc_timeout = 1'b1;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'h0;
            mem_wdata_o <= 32'h0;
            if_rdata_o  <= 32'h0;
            dm_rdata_o  <= 32'h0;
            if_ack_o    <= 1'b0;
            dm_ack_o    <= 1'b0;
            err_o       <= 1'b0;
            wait_cnt    <= 8'd0;
        end else begin
            if_ack_o <= (state == IF_ACC) && (acc_done || acc_timeout);
            dm_ack_o <= (state == DM_ACC) && (acc_done || acc_timeout);

            if (grant_dm) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= dm_we_i;
                mem_addr_o  <= dm_addr_i;
                mem_wdata_o <= dm_wdata_i;
                wait_cnt    <= 8'd0;
            end else if (grant_if) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= 1'b0;
                mem_addr_o  <= if_addr_i;
                mem_wdata_o <= 32'h0;
                wait_cnt    <= 8'd0;
            end else if (acc_done || acc_timeout) begin
                mem_req_o <= 1'b0;
                mem_we_o  <= 1'b0;
            end else if (in_acc) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            if (acc_done && !mem_we_o) begin
                if (state == IF_ACC) begin
                    if_rdata_o <= mem_rdata_i;
                end else begin
                    dm_rdata_o <= mem_rdata_i;
                end
            end

            if (acc_timeout) begin
                err_o <= 1'b1;
            end
        end
    end

`ifdef MEM_ARBITER_PERF_EN
    // All counters saturate rather than wrap.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cycles_o <= 32'h0;
            if_grants_o    <= 16'h0;
            dm_grants_o    <= 16'h0;
        end else begin
            if (stall_o && (stall_cycles_o != 32'hFFFF_FFFF)) begin
                stall_cycles_o <= stall_cycles_o + 32'd1;
            end
            if (grant_if && (if_grants_o != 16'hFFFF)) begin
                if_grants_o <= if_grants_o + 16'd1;
            end
            if (grant_dm && (dm_grants_o != 16'hFFFF)) begin
                dm_grants_o <= dm_grants_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the MEM_ARBITER_PERF_EN build also
// checks that the performance counters clear on reset.
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_ack_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        stall_o;
    logic        err_o;
`ifdef MEM_ARBITER_PERF_EN
    logic [31:0] stall_cycles_o;
    logic [15:0] if_grants_o;
    logic [15:0] dm_grants_o;
`endif

    int pass_count  = 0;
    int check_count = 0;

    mem_arbiter dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_ack_o    (if_ack_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_rdata_o  (dm_rdata_o),
        .dm_ack_o    (dm_ack_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .stall_o     (stall_o),
        .err_o       (err_o)
`ifdef MEM_ARBITER_PERF_EN
        ,
        .stall_cycles_o (stall_cycles_o),
        .if_grants_o    (if_grants_o),
        .dm_grants_o    (dm_grants_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic if_req, input logic [31:0] if_addr,
                                 input logic dm_req, input logic dm_we,
                                 input logic [31:0] dm_addr, input logic [31:0] dm_wdata,
                                 input logic mem_ack, input logic [31:0] mem_rdata);
        if_req_i    = if_req;
        if_addr_i   = if_addr;
        dm_req_i    = dm_req;
        dm_we_i     = dm_we;
        dm_addr_i   = dm_addr;
        dm_wdata_i  = dm_wdata;
        mem_ack_i   = mem_ack;
        mem_rdata_i = mem_rdata;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end else begin
            pass_count++;
        end
    endtask

    initial begin
        int n;
        rst_i = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("rst_mem_req", {31'b0, mem_req_o}, 0);
        checkOutput("rst_acks", {30'b0, if_ack_o, dm_ack_o}, 0);
        checkOutput("rst_err", {31'b0, err_o}, 0);
        checkOutput("rst_addr", mem_addr_o, 0);
        checkOutput("rst_if_rdata", if_rdata_o, 0);
        rst_i = 1'b1;
        tick();

        $display("[TB] IF read, zero-wait ack");
        applyStimulus(1, 32'h10, 0, 0, 0, 0, 1, 32'h8C01_0004);
        checkOutput("if_stall_c0", {31'b0, stall_o}, 1);
        tick();
        checkOutput("if_mem_req_c1", {31'b0, mem_req_o}, 1);
        checkOutput("if_mem_addr_c1", mem_addr_o, 32'h10);
        checkOutput("if_mem_we_c1", {31'b0, mem_we_o}, 0);
        checkOutput("if_stall_c1", {31'b0, stall_o}, 1);
        checkOutput("if_ack_c1", {31'b0, if_ack_o}, 0);
        tick();
        checkOutput("if_ack_c2", {31'b0, if_ack_o}, 1);
        checkOutput("if_rdata_c2", if_rdata_o, 32'h8C01_0004);
        checkOutput("if_mem_req_c2", {31'b0, mem_req_o}, 0);
        checkOutput("if_stall_c2", {31'b0, stall_o}, 0);
        applyStimulus(0, 32'h10, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("if_ack_c3", {31'b0, if_ack_o}, 0);

        $display("[TB] simultaneous IF and DM requests");
        applyStimulus(1, 32'h100, 1, 0, 32'h20, 0, 0, 0);
        tick();
        checkOutput("arb_first_addr", mem_addr_o, 32'h20);
        checkOutput("arb_first_req", {31'b0, mem_req_o}, 1);
        applyStimulus(1, 32'h100, 1, 0, 32'h20, 0, 1, 32'h1111_2222);
        tick();
        checkOutput("arb_dm_acks", {30'b0, if_ack_o, dm_ack_o}, 2'b01);
        checkOutput("arb_dm_rdata", dm_rdata_o, 32'h1111_2222);
        applyStimulus(1, 32'h100, 0, 0, 32'h20, 0, 0, 0);
        tick();
        checkOutput("arb_idle_acks", {30'b0, if_ack_o, dm_ack_o}, 0);
        tick();
        checkOutput("arb_second_addr", mem_addr_o, 32'h100);
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 1, 32'h3333_4444);
        tick();
        checkOutput("arb_if_acks", {30'b0, if_ack_o, dm_ack_o}, 2'b10);
        checkOutput("arb_if_rdata", if_rdata_o, 32'h3333_4444);
        checkOutput("arb_dm_rdata_hold", dm_rdata_o, 32'h1111_2222);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("[TB] DM write with three wait cycles");
        applyStimulus(0, 0, 1, 1, 32'h40, 32'hDEAD_BEEF, 0, 0);
        tick();
        applyStimulus(0, 0, 1, 1, 32'h99, 32'h0, 0, 32'hBAD0_BAD0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("wr_we_%0d", i), {31'b0, mem_we_o}, 1);
            checkOutput($sformatf("wr_addr_%0d", i), mem_addr_o, 32'h40);
            checkOutput($sformatf("wr_wdata_%0d", i), mem_wdata_o, 32'hDEAD_BEEF);
            checkOutput($sformatf("wr_ack_%0d", i), {31'b0, dm_ack_o}, 0);
            if (i == 3) begin
                applyStimulus(0, 0, 1, 1, 32'h99, 32'h0, 1, 32'hBAD0_BAD0);
            end
            tick();
        end
        checkOutput("wr_dm_ack", {31'b0, dm_ack_o}, 1);
        checkOutput("wr_dm_rdata", dm_rdata_o, 32'h1111_2222);
        checkOutput("wr_mem_req", {31'b0, mem_req_o}, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("wr_ack_pulse", {31'b0, dm_ack_o}, 0);

        $display("[TB] IF read with no memory ack");
        applyStimulus(1, 32'h200, 0, 0, 0, 0, 0, 32'hFFFF_0000);
        tick();
        n = 0;
        while (mem_req_o === 1'b1 && n < 400) begin
            n++;
            tick();
        end
        checkOutput("to_req_cycles", n, 255);
        checkOutput("to_if_ack", {31'b0, if_ack_o}, 1);
        checkOutput("to_err", {31'b0, err_o}, 1);
        checkOutput("to_if_rdata", if_rdata_o, 32'h3333_4444);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        tick();
        checkOutput("to_err_sticky", {31'b0, err_o}, 1);
        checkOutput("to_ack_pulse", {31'b0, if_ack_o}, 0);

        $display("[TB] reset during DM access");
        applyStimulus(0, 0, 1, 0, 32'h80, 0, 0, 0);
        tick();
        checkOutput("ra_mem_req_before", {31'b0, mem_req_o}, 1);
        rst_i = 1'b0;
        tick();
        checkOutput("ra_mem_req", {31'b0, mem_req_o}, 0);
        checkOutput("ra_dm_ack", {31'b0, dm_ack_o}, 0);
        checkOutput("ra_err", {31'b0, err_o}, 0);
        checkOutput("ra_dm_rdata", dm_rdata_o, 0);
`ifdef MEM_ARBITER_PERF_EN
        checkOutput("ra_stall_cycles", stall_cycles_o, 0);
        checkOutput("ra_if_grants", {16'b0, if_grants_o}, 0);
        checkOutput("ra_dm_grants", {16'b0, dm_grants_o}, 0);
`endif
        rst_i = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("ra_idle_req", {31'b0, mem_req_o}, 0);
        checkOutput("ra_idle_ack", {31'b0, dm_ack_o}, 0);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
